bsg_circular_ptr_modulo: RTL and testbench
==========================================

# bsg_circular_ptr_modulo

Parametrised circular pointer for queues and ring buffers whose slot count is not necessarily a power of two. Each cycle it advances a registered pointer by a variable amount, from 0 to `max_add_p`, modulo `slots_p`. It keeps a lap bit that toggles on every wrap, so FIFO full and empty can be told apart, and it supports a synchronous load for flush and rewind. It sits in FIFO, ROB and credit-ring control, one instance per read or write side.

## Interface

Parameters:
- `slots_p`, default 10: number of slots. Must be ≥ 2; any integer is allowed.
- `max_add_p`, default 9: largest legal increment. Must satisfy 1 ≤ `max_add_p` < `slots_p`.
- Derived `ptr_width_lp` = `$clog2(slots_p)`.
- Derived `add_width_lp` = `$clog2(max_add_p+1)`.

Ports:
- `clk` in 1: clock; single clock domain.
- `reset_i` in 1: reset, **asynchronous, active-high**.
- `add_i` in `add_width_lp`: increment applied at the next `clk` rising edge; 0 means hold.
- `load_v_i` in 1: load strobe; takes priority over `add_i`.
- `load_i` in `ptr_width_lp`: pointer value to load; must be < `slots_p`.
- `load_lap_i` in 1: lap value to load together with `load_i`.
- `o` out `ptr_width_lp`: registered current pointer.
- `lap_o` out 1: registered lap bit.
- `n_o` out `ptr_width_lp`: combinational next pointer, computed from `o` and `add_i` only (load is ignored).
- `wrap_o` out 1: combinational; 1 when `o` + `add_i` ≥ `slots_p`.

## Operation

- Sum arithmetic:
  - `sum` = `o` + `add_i`, computed at width `ptr_width_lp`+1 so it cannot overflow.
  - `wrap_o` = (`sum` ≥ `slots_p`).
  - `n_o` = `wrap_o` ? `sum` − `slots_p` : `sum`.
  - Because `max_add_p` < `slots_p`, at most one wrap can occur per add.
- Power-of-two `slots_p`: the compare/subtract must reduce to plain truncation. It must give results identical to the generic path.
- State update, in priority order:
  - `reset_i`=1: `o`=0, `lap_o`=0, applied immediately (asynchronous).
  - `load_v_i`=1: `o`←`load_i`, `lap_o`←`load_lap_i`. `add_i` is ignored that cycle.
  - Otherwise: `o`←`n_o`, `lap_o`←`lap_o` ^ `wrap_o`.
- Illegal inputs, caught by simulation-only assertions (disabled during reset); RTL behaviour is undefined:
  - `add_i` > `max_add_p`.
  - `load_v_i`=1 with `load_i` ≥ `slots_p`.
  - Parameters violating the constraints above (elaboration error).
- Invariant: `o` < `slots_p` at every clock edge outside reset.

## Timing

- Reset values: `o`=0, `lap_o`=0.
- While `reset_i` is high, `n_o`=`add_i` and `wrap_o`=0. This holds because `add_i` ≤ `max_add_p` < `slots_p`.
- Assertion of `reset_i` clears state asynchronously, with no clock needed.
- Deassertion must be synchronous to `clk`, which is the integrator's responsibility. The first update happens at the first `clk` edge with `reset_i` low.
- Latency:
  - `n_o` and `wrap_o` are valid in the same cycle as `add_i`, with zero latency; this path is combinational from both `o` and `add_i`.
  - `o` and `lap_o` reflect an add or load one cycle later.
- Consecutive adds apply every cycle with no bubbles.
- Load and add in the same cycle: the load wins. `n_o`/`wrap_o` still show the add result that cycle; this is deliberate so consumers can read them without gating on load.
- Reset in the middle of a wrap or load cancels the pending update.
- No handshake: the consumer must not drive `add_i` larger than the number of slots it is actually consuming.

## Test plan

Default parameters (`slots_p`=10, `max_add_p`=9; pointer and add are both 4 bits):

- Reset to steady add:
  - Assert `reset_i` asynchronously mid-cycle → `o`=0 and `lap_o`=0 immediately.
  - Release, then `add_i`=3 for 4 cycles → `o` = 3, 6, 9, 2; `lap_o` goes 0→1 on the 9→2 step, where `wrap_o`=1.
- Exact boundary:
  - `o`=7, `add_i`=3 → `n_o`=0, `wrap_o`=1; after the edge `o`=0 and `lap_o` is toggled.
  - `o`=6, `add_i`=3 → `n_o`=9, `wrap_o`=0.
- Max add:
  - `o`=9, `add_i`=9 → `n_o`=8, `wrap_o`=1.
  - Ten consecutive cycles of `add_i`=9 from 0 → `o` visits all residues (0, 9, 8, …, 1) and `lap_o` toggles 9 times.
- Load priority:
  - `o`=5, `add_i`=4, `load_v_i`=1, `load_i`=2, `load_lap_i`=1 → `n_o`=9 that cycle; next cycle `o`=2, `lap_o`=1.
  - Hold cycle `add_i`=0 → `o` stays 2.
- Reset mid-operation:
  - `o`=8, `add_i`=5, with `reset_i` asserted half a cycle before the edge → after the edge `o`=0, `lap_o`=0 (no wrap recorded).
- Power-of-two parameters (`slots_p`=16, `max_add_p`=15):
  - Random `add_i` for 10k cycles; compare against reference model `(o+add)%16`, with lap toggling when `o`+`add` ≥ 16.
  - Repeat the same model check with `slots_p`=10 and `slots_p`=7 (`max_add_p`=6). No assertion may fire.

Source files
------------

// File: rtl/bsg_circular_ptr_modulo.sv
// bsg_circular_ptr_modulo
// Circular pointer for rings whose slot count need not be a power of two.
// Each cycle the registered pointer advances by 0..max_add_p modulo slots_p.
// A lap bit flips on every wrap so that FIFO full and empty can be told apart.
// A synchronous load (flush / rewind) takes priority over the add.
// n_o / wrap_o are the combinational add result and ignore the load. This lets
// consumers use them without gating on load_v_i.

module bsg_circular_ptr_modulo #(
  parameter int slots_p   = 10,
  parameter int max_add_p = 9,
  localparam int ptr_width_lp = $clog2(slots_p),
  localparam int add_width_lp = $clog2(max_add_p + 1)
) (
  input  logic                    clk,
  input  logic                    reset_i,
  input  logic [add_width_lp-1:0] add_i,
  input  logic                    load_v_i,
  input  logic [ptr_width_lp-1:0] load_i,
  input  logic                    load_lap_i,
  output logic [ptr_width_lp-1:0] o,
  output logic                    lap_o,
  output logic [ptr_width_lp-1:0] n_o,
  output logic                    wrap_o
);

  // One extra bit of headroom, so o + add_i cannot overflow.
  localparam int sum_width_lp = ptr_width_lp + 1;

  // Power-of-two ring: the modulo collapses to dropping the carry bit.
  localparam bit pow2_lp = ((slots_p & (slots_p - 1)) == 0);

  localparam logic [sum_width_lp-1:0] slots_lp   = sum_width_lp'(slots_p);
  localparam logic [add_width_lp-1:0] max_add_lp = add_width_lp'(max_add_p);

  // Reject parameter sets that would break the single-wrap assumption.
  if (slots_p < 2) begin : g_bad_slots
    $error("bsg_circular_ptr_modulo: slots_p must be >= 2");
  end
  if (max_add_p < 1 || max_add_p >= slots_p) begin : g_bad_max_add
    $error("bsg_circular_ptr_modulo: max_add_p must satisfy 1 <= max_add_p < slots_p");
  end

  logic [sum_width_lp-1:0] sum;

  // Unwrapped sum of the current pointer and the requested increment.
  assign sum = {1'b0, o} + sum_width_lp'(add_i);

  if (pow2_lp) begin : g_pow2
    // The carry out of the pointer field is exactly the wrap.
    assign wrap_o = sum[ptr_width_lp];
    assign n_o    = sum[ptr_width_lp-1:0];
  end else begin : g_generic
    // add_i < slots_p, so one conditional subtract is a full modulo.
    assign wrap_o = (sum >= slots_lp);
    assign n_o    = wrap_o ? ptr_width_lp'(sum - slots_lp)
                           : ptr_width_lp'(sum);
  end

  // Pointer and lap state. Priority is reset, then load, then add.
  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples values from before the edge and no update order can race.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      o     <= '0;
      lap_o <= 1'b0;
    end else if (load_v_i) begin
      o     <= load_i;
      lap_o <= load_lap_i;
    end else begin
      o     <= n_o;
      lap_o <= lap_o ^ wrap_o;
    end
  end

`ifndef SYNTHESIS
  // Increments beyond max_add_p could wrap twice and corrupt the lap bit.
  assert property (@(posedge clk) disable iff (reset_i)
    add_i <= max_add_lp);

  // A loaded pointer has to name a real slot.
  assert property (@(posedge clk) disable iff (reset_i)
    !load_v_i || ({1'b0, load_i} < slots_lp));

  // The pointer stays inside the ring outside of reset.
  assert property (@(posedge clk) disable iff (reset_i)
    {1'b0, o} < slots_lp);
`endif

endmodule

// File: tb/tb_bsg_circular_ptr_modulo.sv
// tb_bsg_circular_ptr_modulo
// Directed checks on the default 10-slot ring. Reference-model runs follow on
// 10-, 16- and 7-slot rings, all sharing one clock and one reset.

module tb_bsg_circular_ptr_modulo;

  logic clk = 1'b0;
  logic reset_i;

  // Free-running clock: 10 time-unit period, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Default instance: slots_p=10, max_add_p=9 (4-bit pointer and add).
  logic [3:0] add10, load10, o10, n10;
  logic       load_v10, load_lap10, lap10, wrap10;

  // Power-of-two instance: slots_p=16, max_add_p=15.
  logic [3:0] add16, load16, o16, n16;
  logic       load_v16, load_lap16, lap16, wrap16;

  // Odd instance: slots_p=7, max_add_p=6 (3-bit pointer and add).
  logic [2:0] add7, load7, o7, n7;
  logic       load_v7, load_lap7, lap7, wrap7;

  bsg_circular_ptr_modulo u_dut10 (
    .clk(clk), .reset_i(reset_i), .add_i(add10), .load_v_i(load_v10),
    .load_i(load10), .load_lap_i(load_lap10), .o(o10), .lap_o(lap10),
    .n_o(n10), .wrap_o(wrap10)
  );

  bsg_circular_ptr_modulo #(.slots_p(16), .max_add_p(15)) u_dut16 (
    .clk(clk), .reset_i(reset_i), .add_i(add16), .load_v_i(load_v16),
    .load_i(load16), .load_lap_i(load_lap16), .o(o16), .lap_o(lap16),
    .n_o(n16), .wrap_o(wrap16)
  );

  bsg_circular_ptr_modulo #(.slots_p(7), .max_add_p(6)) u_dut7 (
    .clk(clk), .reset_i(reset_i), .add_i(add7), .load_v_i(load_v7),
    .load_i(load7), .load_lap_i(load_lap7), .o(o7), .lap_o(lap7),
    .n_o(n7), .wrap_o(wrap7)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Load the default instance via its synchronous load port.
  task automatic load_10(input int v, input bit l);
    load_v10   = 1'b1;
    load10     = 4'(v);
    load_lap10 = l;
    add10      = '0;
    cycle();
    load_v10   = 1'b0;
  endtask

  int exp_o3 [4] = '{3, 6, 9, 2};
  int exp_l3 [4] = '{0, 0, 0, 1};
  int exp_w3 [4] = '{0, 0, 0, 1};
  int exp_o9 [10] = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
  int exp_l9 [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};

  initial begin
    int  toggles;
    bit  prev_lap;
    int  m10, m16, m7;
    bit  ml10, ml16, ml7;
    int  a10, a16, a7, li10, li16, li7;
    bit  lv10, lv16, lv7, ll10, ll16, ll7;

    reset_i = 1'b1;
    add10 = '0; load_v10 = 1'b0; load10 = '0; load_lap10 = 1'b0;
    add16 = '0; load_v16 = 1'b0; load16 = '0; load_lap16 = 1'b0;
    add7  = '0; load_v7  = 1'b0; load7  = '0; load_lap7  = 1'b0;
    repeat (2) cycle();
    check("reset o16", o16, 0);
    check("reset lap16", lap16, 0);
    check("reset o7", o7, 0);
    check("reset lap7", lap7, 0);
    reset_i = 1'b0;

    // ---- Reset to steady add ----
    load_10(5, 1'b1);
    check("preload o", o10, 5);
    check("preload lap", lap10, 1);
    #3 reset_i = 1'b1;               // mid-cycle, no clock edge follows yet
    #1;
    check("async reset o", o10, 0);
    check("async reset lap", lap10, 0);
    add10 = 4'd7;
    #1;
    check("reset n_o=add", n10, 7);
    check("reset wrap=0", wrap10, 0);
    cycle();
    reset_i = 1'b0;
    add10   = 4'd3;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("add3 wrap", wrap10, exp_w3[i]);
      cycle();
      check("add3 o", o10, exp_o3[i]);
      check("add3 lap", lap10, exp_l3[i]);
    end

    // ---- Exact boundary ----
    load_10(7, 1'b0);
    add10 = 4'd3;
    #1;
    check("7+3 n_o", n10, 0);
    check("7+3 wrap", wrap10, 1);
    cycle();
    check("7+3 o", o10, 0);
    check("7+3 lap", lap10, 1);
    load_10(6, 1'b0);
    add10 = 4'd3;
    #1;
    check("6+3 n_o", n10, 9);
    check("6+3 wrap", wrap10, 0);
    cycle();
    check("6+3 o", o10, 9);
    check("6+3 lap", lap10, 0);

    // ---- Max add ----
    add10 = 4'd9;
    #1;
    check("9+9 n_o", n10, 8);
    check("9+9 wrap", wrap10, 1);
    load_10(0, 1'b0);
    toggles = 0;
    add10   = 4'd9;
    for (int i = 0; i < 10; i++) begin
      prev_lap = lap10;
      cycle();
      check("max add o", o10, exp_o9[i]);
      check("max add lap", lap10, exp_l9[i]);
      if (lap10 != prev_lap) toggles++;
    end
    check("max add toggles", toggles, 9);

    // ---- Load priority ----
    load_10(5, 1'b0);
    add10      = 4'd4;
    load_v10   = 1'b1;
    load10     = 4'd2;
    load_lap10 = 1'b1;
    #1;
    check("load n_o", n10, 9);
    check("load wrap", wrap10, 0);
    cycle();
    check("load o", o10, 2);
    check("load lap", lap10, 1);
    load_v10 = 1'b0;
    add10    = 4'd0;
    #1;
    check("hold n_o", n10, 2);
    cycle();
    check("hold o", o10, 2);
    check("hold lap", lap10, 1);

    // ---- Reset mid-operation ----
    load_10(8, 1'b0);
    add10 = 4'd5;
    #1;
    check("8+5 n_o", n10, 3);
    check("8+5 wrap", wrap10, 1);
    #3 reset_i = 1'b1;               // half a cycle before the edge
    #1;
    check("midop async o", o10, 0);
    cycle();
    check("midop o", o10, 0);
    check("midop lap", lap10, 0);
    #4 reset_i = 1'b0;
    add10 = 4'd0;
    cycle();
    check("post reset o", o10, 0);
    check("post reset lap", lap10, 0);

    // ---- Reference-model runs on all three rings ----
    m10 = 0; m16 = 0; m7 = 0;
    ml10 = 1'b0; ml16 = 1'b0; ml7 = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      a10 = int'($urandom_range(0, 9));
      a16 = int'($urandom_range(0, 15));
      a7  = int'($urandom_range(0, 6));
      lv10 = ($urandom_range(0, 31) == 0);
      lv16 = ($urandom_range(0, 31) == 0);
      lv7  = ($urandom_range(0, 31) == 0);
      li10 = int'($urandom_range(0, 9));
      li16 = int'($urandom_range(0, 15));
      li7  = int'($urandom_range(0, 6));
      ll10 = 1'($urandom_range(0, 1));
      ll16 = 1'($urandom_range(0, 1));
      ll7  = 1'($urandom_range(0, 1));
      add10 = 4'(a10); load_v10 = lv10; load10 = 4'(li10); load_lap10 = ll10;
      add16 = 4'(a16); load_v16 = lv16; load16 = 4'(li16); load_lap16 = ll16;
      add7  = 3'(a7);  load_v7  = lv7;  load7  = 3'(li7);  load_lap7  = ll7;
      #1;
      check("m10 n_o", n10, (m10 + a10) % 10);
      check("m10 wrap", wrap10, (m10 + a10) >= 10);
      check("m16 n_o", n16, (m16 + a16) % 16);
      check("m16 wrap", wrap16, (m16 + a16) >= 16);
      check("m7 n_o", n7, (m7 + a7) % 7);
      check("m7 wrap", wrap7, (m7 + a7) >= 7);
      cycle();
      if (lv10) begin m10 = li10; ml10 = ll10; end
      else begin ml10 ^= ((m10 + a10) >= 10); m10 = (m10 + a10) % 10; end
      if (lv16) begin m16 = li16; ml16 = ll16; end
      else begin ml16 ^= ((m16 + a16) >= 16); m16 = (m16 + a16) % 16; end
      if (lv7) begin m7 = li7; ml7 = ll7; end
      else begin ml7 ^= ((m7 + a7) >= 7); m7 = (m7 + a7) % 7; end
      check("m10 o", o10, m10);
      check("m10 lap", lap10, ml10);
      check("m16 o", o16, m16);
      check("m16 lap", lap16, ml16);
      check("m7 o", o7, m7);
      check("m7 lap", lap7, ml7);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
